// File: rtl/alu_ctrl_pipe.sv
// Registered ALU control unit: decodes ALUOp/Funct3/Funct7 into an operation code behind a
// valid/ready handshake and sequences multi-cycle RV32M MUL (fixed latency) and DIV/REM (done/timeout).
module alu_ctrl_pipe #(
    parameter int OP_W        = 5,
    parameter bit ENABLE_M    = 1'b1,
    parameter int MUL_LAT     = 3,
    parameter int DIV_TIMEOUT = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            r_type,
    input  logic [1:0]      alu_op,
    input  logic [6:0]      funct7,
    input  logic [2:0]      funct3,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [OP_W-1:0] operation,
    output logic            is_mdu,
    output logic            illegal,
    output logic            timeout,
    output logic            mdu_start,
    output logic            mdu_abort,
    input  logic            mdu_done
);

    localparam int CNT_MAX = (MUL_LAT > DIV_TIMEOUT) ? MUL_LAT : DIV_TIMEOUT;
    localparam int CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX);

    localparam logic [4:0] OP_AND  = 5'b00000;
    localparam logic [4:0] OP_XOR  = 5'b00001;
    localparam logic [4:0] OP_SUB  = 5'b00010;
    localparam logic [4:0] OP_OR   = 5'b00011;
    localparam logic [4:0] OP_ADD  = 5'b00100;
    localparam logic [4:0] OP_BGE  = 5'b00101;
    localparam logic [4:0] OP_BNE  = 5'b00110;
    localparam logic [4:0] OP_SRA  = 5'b00111;
    localparam logic [4:0] OP_BEQ  = 5'b01000;
    localparam logic [4:0] OP_SLL  = 5'b01001;
    localparam logic [4:0] OP_LUI  = 5'b01010;
    localparam logic [4:0] OP_BLTU = 5'b01011;
    localparam logic [4:0] OP_SRL  = 5'b01100;
    localparam logic [4:0] OP_BLT  = 5'b01101;
    localparam logic [4:0] OP_SLT  = 5'b01110;
    localparam logic [4:0] OP_SLTU = 5'b01111;
    localparam logic [4:0] OP_BGEU = 5'b11001;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [6:0] F7_MUL  = 7'b0000001;

    typedef enum logic [1:0] {IDLE, MUL_WAIT, DIV_WAIT, HOLD} state_t;

    typedef struct packed {
        logic [4:0] code;
        logic       mdu;
        logic       ill;
    } dec_t;

    function automatic dec_t decode(input logic       is_r,
                                    input logic [1:0] op,
                                    input logic [6:0] f7,
                                    input logic [2:0] f3);
        dec_t d;
        d.code = OP_ADD;
        d.mdu  = 1'b0;
        d.ill  = 1'b0;
        case (op)
            2'b00: d.code = OP_ADD;
            2'b11: d.code = OP_LUI;
            2'b01: begin
                case (f3)
                    3'b000:  d.code = OP_BEQ;
                    3'b001:  d.code = OP_BNE;
                    3'b100:  d.code = OP_BLT;
                    3'b101:  d.code = OP_BGE;
                    3'b110:  d.code = OP_BLTU;
                    3'b111:  d.code = OP_BGEU;
                    default: d.ill  = 1'b1;
                endcase
            end
            default: begin
                if (is_r && f7 == F7_MUL) begin
                    if (ENABLE_M) begin
                        d.code = {2'b10, f3};
                        d.mdu  = 1'b1;
                    end else begin
                        d.ill = 1'b1;
                    end
                end else if (is_r && f7 != F7_BASE && f7 != F7_ALT) begin
                    d.ill = 1'b1;
                end else begin
                    // I-type shifts carry their funct7 in imm[11:5], so shift checks ignore is_r
                    case (f3)
                        3'b000: d.code = (is_r && f7 == F7_ALT) ? OP_SUB : OP_ADD;
                        3'b001: begin
                            if (f7 == F7_BASE) d.code = OP_SLL;
                            else               d.ill  = 1'b1;
                        end
                        3'b010: d.code = OP_SLT;
                        3'b011: d.code = OP_SLTU;
                        3'b100: d.code = OP_XOR;
                        3'b101: begin
                            if (f7 == F7_BASE)     d.code = OP_SRL;
                            else if (f7 == F7_ALT) d.code = OP_SRA;
                            else                   d.ill  = 1'b1;
                        end
                        3'b110:  d.code = OP_OR;
                        default: d.code = OP_AND;
                    endcase
                end
            end
        endcase
        if (d.ill) begin
            d.code = OP_ADD;
            d.mdu  = 1'b0;
        end
        return d;
    endfunction

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              out_valid_q, out_valid_d;
    logic [OP_W-1:0]   operation_q, operation_d;
    logic              is_mdu_q, is_mdu_d;
    logic              illegal_q, illegal_d;
    logic              timeout_q, timeout_d;
    logic              mdu_start_q, mdu_start_d;
    logic              mdu_abort_q, mdu_abort_d;
    dec_t              dec;
    logic              accept;

    assign in_ready = rst_n & (state_q == IDLE) & (~out_valid_q | out_ready);
    assign accept   = in_valid & in_ready;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        operation_d = operation_q;
        is_mdu_d    = is_mdu_q;
        illegal_d   = illegal_q;
        timeout_d   = timeout_q;
        mdu_start_d = 1'b0;
        mdu_abort_d = 1'b0;
        dec         = decode(r_type, alu_op, funct7, funct3);

        if (flush) begin
            state_d     = IDLE;
            cnt_d       = '0;
            out_valid_d = 1'b0;
            operation_d = '0;
            is_mdu_d    = 1'b0;
            illegal_d   = 1'b0;
            timeout_d   = 1'b0;
            mdu_abort_d = (state_q == DIV_WAIT);
        end else begin
            case (state_q)
                IDLE: begin
                    if (out_valid_q) begin
                        if (out_ready) out_valid_d = 1'b0;
                        else           state_d     = HOLD;
                    end
                    if (accept) begin
                        operation_d = OP_W'(dec.code);
                        is_mdu_d    = dec.mdu;
                        illegal_d   = dec.ill;
                        timeout_d   = 1'b0;
                        cnt_d       = '0;
                        if (dec.mdu && funct3[2]) begin
                            state_d     = DIV_WAIT;
                            mdu_start_d = 1'b1;
                            out_valid_d = 1'b0;
                        end else if (dec.mdu && MUL_LAT > 1) begin
                            state_d     = MUL_WAIT;
                            cnt_d       = CNT_W'(MUL_LAT - 1);
                            out_valid_d = 1'b0;
                        end else begin
                            out_valid_d = 1'b1;
                        end
                    end
                end
                MUL_WAIT: begin
                    if (cnt_q == '0) begin
                        out_valid_d = 1'b1;
                        state_d     = IDLE;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                DIV_WAIT: begin
                    // a done arriving on the timeout cycle still counts as a completion
                    if (mdu_done) begin
                        out_valid_d = 1'b1;
                        state_d     = IDLE;
                        cnt_d       = '0;
                    end else if (DIV_TIMEOUT != 0 && cnt_q == CNT_W'(DIV_TIMEOUT - 1)) begin
                        out_valid_d = 1'b1;
                        timeout_d   = 1'b1;
                        mdu_abort_d = 1'b1;
                        state_d     = IDLE;
                        cnt_d       = '0;
                    end else if (DIV_TIMEOUT != 0) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid_d = 1'b0;
                        state_d     = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            operation_q <= '0;
            is_mdu_q    <= 1'b0;
            illegal_q   <= 1'b0;
            timeout_q   <= 1'b0;
            mdu_start_q <= 1'b0;
            mdu_abort_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            operation_q <= operation_d;
            is_mdu_q    <= is_mdu_d;
            illegal_q   <= illegal_d;
            timeout_q   <= timeout_d;
            mdu_start_q <= mdu_start_d;
            mdu_abort_q <= mdu_abort_d;
        end
    end

    assign out_valid = out_valid_q;
    assign operation = operation_q;
    assign is_mdu    = is_mdu_q;
    assign illegal   = illegal_q;
    assign timeout   = timeout_q;
    assign mdu_start = mdu_start_q;
    assign mdu_abort = mdu_abort_q;

endmodule
